pack_n: RTL and testbench

Sequential stream packer: accepts DW-bit words one per handshake and assembles them into an N-lane packed bus of DW*N bits, with lane 0 in the least-significant DW bits. It is the producer side of the packed-lane interface used by the combinational N-input adder. A serial sample stream, such as a sensor or FIFO read port, feeds it, and its output drives the adder's packed input directly. Partial frames are zero-padded, so a downstream sum stays correct.

---
 rtl/pack_pkg.sv | 37 +++
 rtl/pack_n_if.sv | 31 +++
 rtl/pack_n_out_slot.sv | 49 ++++
 rtl/pack_n.sv | 114 +++++++++++
 tb/tb_pack_n.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/pack_pkg.sv
// Shared definitions for the pack_n stream packer and its packed-lane consumers.
//
// Packed-bus ordering: an N-lane bus of DW-bit lanes is a flat DW*N vector with
// lane 0 in the least-significant DW bits; lane i occupies [(i+1)*DW-1 : i*DW].
// The packer produces this ordering and the N-input adder consumes it unchanged.
package pack_pkg;

  localparam int DEFAULT_N  = 4;
  localparam int DEFAULT_DW = 8;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x * 2;
      r++;
    end
    return r;
  endfunction

  // Width of a lane-count field able to hold 0..n.
  function automatic int lane_w(input int n);
    return clog2(n + 1);
  endfunction

  // Width of a lane index 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Lane-count width for the default configuration.
  localparam int DEFAULT_LW = lane_w(DEFAULT_N);

endpackage

// File: rtl/pack_n_if.sv
// Word-in / packed-frame-out handshake bundle for pack_n.
// master: the environment (word source and frame sink); slave: the packer.
interface pack_n_if
  import pack_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int DW = DEFAULT_DW
) ();

  localparam int LW = lane_w(N);

  logic [DW-1:0]   in_data;
  logic            in_valid;
  logic            in_last;
  logic            in_ready;
  logic [DW*N-1:0] out_data;
  logic [LW-1:0]   out_lanes;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_lanes, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_lanes, out_valid
  );

endinterface

// File: rtl/pack_n_out_slot.sv
// Single-entry registered output stage: holds one payload with a valid flag.
// The caller only asserts load while free is high, so the payload is stable
// whenever valid is held without ready.
module pack_n_out_slot #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [PW-1:0] load_payload,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [PW-1:0] out_payload,
  output logic          free
);

  logic          valid_q, valid_d;
  logic [PW-1:0] payload_q, payload_d;

  // Free when empty or when the current entry leaves on this edge.
  assign free        = !valid_q || out_ready;
  assign out_valid   = valid_q;
  assign out_payload = payload_q;

  // Next slot contents: drain on handshake, load overrides so drain+load keeps valid high.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    valid_d   = valid_q;
    payload_d = payload_q;
    if (valid_q && out_ready) valid_d = 1'b0;
    if (load) begin
      valid_d   = 1'b1;
      payload_d = load_payload;
    end
  end

  // Slot register with synchronous reset of both flag and payload.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all flops sample pre-edge values together.
    if (rst) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

endmodule

// File: rtl/pack_n.sv
// Stream packer: collects DW-bit words into an N-lane frame (lane 0 at LSBs),
// zero-pads short frames closed by in_last, and hands frames to a one-entry
// output slot. A frame completing while the slot is busy waits in the
// collection buffer (pend) and stalls input until the slot frees.
module pack_n
  import pack_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int DW = DEFAULT_DW
) (
  input logic     clk,
  input logic     rst,
  pack_n_if.slave bus
);

  localparam int LW = lane_w(N);
  localparam int CW = cnt_w(N);
  localparam int FW = DW * N;
  localparam int PW = FW + LW;
  localparam logic [CW-1:0] LAST_LANE = CW'(N - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] buf_q, buf_d;
  logic          pend_q, pend_d;
  logic [LW-1:0] pend_lanes_q, pend_lanes_d;

  logic          in_ready;
  logic          accept;
  logic          complete;
  logic          slot_free;
  logic          slot_load;
  logic [FW-1:0] frame_data;
  logic [LW-1:0] frame_lanes;
  logic [PW-1:0] slot_payload;
  logic [PW-1:0] out_payload;

  // Ready depends on registered state and reset only, never on out_ready.
  assign in_ready     = !pend_q && !rst;
  assign bus.in_ready = in_ready;
  assign accept       = bus.in_valid && in_ready;
  assign complete     = accept && ((cnt_q == LAST_LANE) || bus.in_last);

  // Frame as it would look with the incoming word written at the current lane
  // and every higher lane masked to zero.
  always_comb begin
    frame_data = buf_q;
    for (int i = 0; i < N; i++) begin
      if (i == int'(cnt_q))     frame_data[i*DW +: DW] = bus.in_data;
      else if (i > int'(cnt_q)) frame_data[i*DW +: DW] = '0;
    end
    frame_lanes = LW'(cnt_q) + LW'(1);
  end

  // A held frame has priority; otherwise a completing frame goes straight in.
  assign slot_load    = slot_free && (pend_q || complete);
  assign slot_payload = pend_q ? {pend_lanes_q, buf_q} : {frame_lanes, frame_data};

  // Collection, completion and pend bookkeeping.
  always_comb begin
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    pend_d       = pend_q;
    pend_lanes_d = pend_lanes_q;
    if (pend_q) begin
      if (slot_free) begin
        pend_d = 1'b0;
        buf_d  = '0;
        cnt_d  = '0;
      end
    end else if (complete) begin
      cnt_d = '0;
      if (slot_free) begin
        buf_d = '0;
      end else begin
        pend_d       = 1'b1;
        buf_d        = frame_data;
        pend_lanes_d = frame_lanes;
      end
    end else if (accept) begin
      buf_d = frame_data;
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Collector state register; reset discards any partial or pending frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      buf_q        <= '0;
      pend_q       <= 1'b0;
      pend_lanes_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      pend_q       <= pend_d;
      pend_lanes_q <= pend_lanes_d;
    end
  end

  pack_n_out_slot #(.PW(PW)) u_out_slot (
    .clk          (clk),
    .rst          (rst),
    .load         (slot_load),
    .load_payload (slot_payload),
    .out_ready    (bus.out_ready),
    .out_valid    (bus.out_valid),
    .out_payload  (out_payload),
    .free         (slot_free)
  );

  assign bus.out_data  = out_payload[FW-1:0];
  assign bus.out_lanes = out_payload[PW-1:FW];

endmodule

// File: tb/tb_pack_n.sv
// Bench for pack_n: directed scenarios plus random traffic on an N=4 and an
// N=1 instance, compared each cycle against a frame-queue reference model.
module tb_pack_n;

  logic clk;
  logic drv_rst;
  logic drv_valid;
  logic [7:0] drv_data;
  logic drv_last;
  logic drv_ordy;
  logic sel;          // 0: N=4 instance active, 1: N=1 instance active
  logic rst4, rst1;

  pack_n_if #(.N(4), .DW(8)) if4 ();
  pack_n_if #(.N(1), .DW(8)) if1 ();

  assign rst4 = drv_rst || (sel != 1'b0);
  assign rst1 = drv_rst || (sel != 1'b1);

  assign if4.in_data   = drv_data;
  assign if4.in_valid  = drv_valid;
  assign if4.in_last   = drv_last;
  assign if4.out_ready = drv_ordy;
  assign if1.in_data   = drv_data;
  assign if1.in_valid  = drv_valid;
  assign if1.in_last   = drv_last;
  assign if1.out_ready = drv_ordy;

  pack_n #(.N(4), .DW(8)) u_dut4 (.clk(clk), .rst(rst4), .bus(if4));
  pack_n #(.N(1), .DW(8)) u_dut1 (.clk(clk), .rst(rst1), .bus(if1));

  logic        obs_ready, obs_valid;
  logic [31:0] obs_data;
  logic [2:0]  obs_lanes;
  assign obs_ready = sel ? if1.in_ready  : if4.in_ready;
  assign obs_valid = sel ? if1.out_valid : if4.out_valid;
  assign obs_data  = sel ? {24'h0, if1.out_data}  : if4.out_data;
  assign obs_lanes = sel ? {2'b0, if1.out_lanes} : if4.out_lanes;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frames waiting to be delivered (front = visible output),
  // plus the words of the frame being collected.
  logic [31:0] q_data[$];
  int          q_lanes[$];
  logic [7:0]  cur[4];
  int          cur_n = 0;
  int          n_lanes = 4;
  bit          rst_zero = 1'b0;

  task automatic model_edge(input logic v, input logic [7:0] d, input logic l,
                            input logic ordy, input logic r, input logic exp_ready);
    logic [31:0] f;
    if (r) begin
      q_data.delete();
      q_lanes.delete();
      cur_n    = 0;
      rst_zero = 1'b1;
    end else begin
      if (ordy && q_data.size() > 0) begin
        void'(q_data.pop_front());
        void'(q_lanes.pop_front());
      end
      if (v && exp_ready) begin
        cur[cur_n] = d;
        cur_n++;
        if (cur_n == n_lanes || (l && n_lanes > 1)) begin
          f = 32'h0;
          for (int i = 0; i < cur_n; i++) f = f | (32'(cur[i]) << (8 * i));
          q_data.push_back(f);
          q_lanes.push_back(cur_n);
          cur_n    = 0;
          rst_zero = 1'b0;
        end
      end
    end
  endtask

  // One clock cycle: drive at negedge, check ready, update model at posedge,
  // check registered outputs at the following negedge.
  task automatic step(input logic v, input logic [7:0] d, input logic l,
                      input logic ordy, input logic r);
    logic exp_ready;
    drv_valid = v;
    drv_data  = d;
    drv_last  = l;
    drv_ordy  = ordy;
    drv_rst   = r;
    exp_ready = !r && (q_data.size() < 2);
    #1;
    check("in_ready", 32'(obs_ready), 32'(exp_ready));
    @(posedge clk);
    model_edge(v, d, l, ordy, r, exp_ready);
    @(negedge clk);
    check("out_valid", 32'(obs_valid), 32'(q_data.size() > 0));
    if (q_data.size() > 0) begin
      check("out_data", obs_data, q_data[0]);
      check("out_lanes", 32'(obs_lanes), 32'(q_lanes[0]));
    end else if (rst_zero) begin
      check("out_data_rst", obs_data, 32'h0);
      check("out_lanes_rst", 32'(obs_lanes), 32'h0);
    end
  endtask

  task automatic random_phase(input int cycles);
    for (int i = 0; i < cycles; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; n_lanes = 4;
    drv_rst = 1'b1; drv_valid = 1'b0; drv_data = 8'h0; drv_last = 1'b0; drv_ordy = 1'b0;
    @(negedge clk);
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);

    // Full frame with out_ready high.
    for (int i = 1; i <= 4; i++) step(1, 8'(i), 0, 1, 0);
    check("full_frame_data", obs_data, 32'h04030201);
    check("full_frame_lanes", 32'(obs_lanes), 32'd4);
    step(0, 8'h00, 0, 1, 0);
    check("full_frame_one_cycle", 32'(obs_valid), 32'd0);

    // Short frame closed by in_last, then the next word starts lane 0.
    step(1, 8'h11, 0, 1, 0);
    step(1, 8'h22, 1, 1, 0);
    check("short_data", obs_data, 32'h00002211);
    check("short_lanes", 32'(obs_lanes), 32'd2);
    for (int i = 0; i < 4; i++) step(1, 8'h31 + 8'(i), 0, 1, 0);
    check("after_short_data", obs_data, 32'h34333231);

    // Backpressure: two frames absorbed, second pends.
    step(0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 8'h10 + 8'(i), 0, 0, 0);
    step(1, 8'h99, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    check("bp_hold_data", obs_data, 32'h13121110);
    step(0, 8'h00, 0, 1, 0);
    check("bp_second_data", obs_data, 32'h17161514);
    step(0, 8'h00, 0, 1, 0);
    check("bp_drained", 32'(obs_valid), 32'd0);

    // Simultaneous drain and load.
    for (int i = 0; i < 7; i++) step(1, 8'h20 + 8'(i), 0, 0, 0);
    step(1, 8'h27, 0, 1, 0);
    check("sim_valid", 32'(obs_valid), 32'd1);
    check("sim_data", obs_data, 32'h27262524);
    step(0, 8'h00, 0, 1, 0);

    // Reset mid-frame discards partial words.
    step(1, 8'hAA, 0, 1, 0);
    step(1, 8'hBB, 0, 1, 0);
    step(0, 8'h00, 0, 1, 1);
    for (int i = 1; i <= 4; i++) step(1, 8'(i), 0, 1, 0);
    check("rst_mid_data", obs_data, 32'h04030201);
    step(0, 8'h00, 0, 1, 0);

    // Sustained throughput, then random traffic.
    for (int i = 0; i < 12; i++) step(1, 8'($urandom), 0, 1, 0);
    random_phase(400);

    // N = 1 instance.
    sel = 1'b1; n_lanes = 1;
    step(0, 8'h00, 0, 0, 1);
    step(1, 8'h5A, 0, 1, 0);
    check("n1_first", obs_data, 32'h0000005A);
    check("n1_lanes", 32'(obs_lanes), 32'd1);
    step(1, 8'hA5, 1, 1, 0);
    check("n1_second", obs_data, 32'h000000A5);
    step(0, 8'h00, 0, 1, 0);
    random_phase(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
